// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the two-port memory arbiter: port identifiers, the request
// and response records, and the address legality check used to decide whether
// an access may touch memory or must be answered with an error.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    // Identifies which requester was granted most recently.
    typedef enum logic {
        PORT_IF   = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    // Addresses are carried zero-extended to this width inside the arbiter so
    // the record types do not depend on the top-level ADDR_W parameter.
    localparam int unsigned ADDR_MAX_W = 64;
    localparam int unsigned DATA_W     = 32;

    typedef struct packed {
        logic                  wen;
        logic [ADDR_MAX_W-1:0] addr;
        logic [DATA_W-1:0]     wdata;
    } mem_req_t;

    typedef struct packed {
        logic              rvalid;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } mem_rsp_t;

    // Legal access: word aligned and word index inside 0..depth-1.
    function automatic logic addr_ok(input logic [ADDR_MAX_W-1:0] addr,
                                     input int unsigned           depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < ADDR_MAX_W'(depth));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, the load/store port and the memory-side signals of
// the arbiter. Signal names match the arbiter's port naming.
//
// Handshake (both requester ports): the requester raises *_req_i and holds
// address (and for data: wen/wdata) stable until it sees *_gnt_o high in the
// same cycle; the access is taken at that clock edge. Exactly one *_rvalid_o
// pulse follows one cycle after each grant, carrying rdata/err. There is no
// back-pressure on responses.
//
// Modports:
//   slave  - arbiter side (drives grants, responses, memory controls)
//   master - environment side (drives requests and memory read data)
// -----------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    // fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              if_err_o;
    // load/store port
    logic              d_req_i;
    logic              d_wen_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [31:0]       d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [31:0]       d_rdata_o;
    logic              d_err_o;
    // memory side
    logic              mem_wen_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;
    // debug: port granted most recently
    port_e             dbg_last_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  d_req_i, d_wen_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_wen_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output dbg_last_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output d_req_i, d_wen_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_wen_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  dbg_last_o
    );

endinterface

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-request round-robin picker. A lone requester always wins; on contention
// the port that was not granted most recently wins. The history register only
// moves when a grant is actually issued.
//
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   req_if_i       fetch request
//   req_d_i        data request
//   gnt_if_o       fetch granted (combinational)
//   gnt_d_o        data granted (combinational)
//   last_o         port granted most recently (state, for debug)
// -----------------------------------------------------------------------------
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  req_if_i,
    input  logic  req_d_i,
    output logic  gnt_if_o,
    output logic  gnt_d_o,
    output port_e last_o
);

    port_e last_q;
    port_e last_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // Reset as if DATA had just been served so fetch wins the first tie.
            last_q <= PORT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt_if_o = 1'b0;
        gnt_d_o  = 1'b0;
        last_d   = last_q;

        if (req_if_i && req_d_i) begin
            if (last_q == PORT_DATA) begin
                gnt_if_o = 1'b1;
            end else begin
                gnt_d_o = 1'b1;
            end
        end else if (req_if_i) begin
            gnt_if_o = 1'b1;
        end else if (req_d_i) begin
            gnt_d_o = 1'b1;
        end

        if (gnt_if_o) begin
            last_d = PORT_IF;
        end else if (gnt_d_o) begin
            last_d = PORT_DATA;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported, word-addressed 32-bit memory between the
// instruction-fetch port (read-only) and the load/store port. At most one
// access is granted per cycle; the memory read data is registered and returned
// with rvalid one cycle after the grant. Misaligned or out-of-range accesses
// are still granted but never write memory and are answered with err=1,
// rdata=0.
//
// Parameters:
//   DEPTH   memory size in 32-bit words
//   ADDR_W  byte address width (at most 64)
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  async active-low reset
//   bus     mem_arbiter_if.slave: both requester ports and the memory side
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    mem_arbiter_if.slave bus
);

    logic     gnt_if;
    logic     gnt_d;
    logic     gnt_any;
    port_e    last;

    mem_req_t if_req;
    mem_req_t d_req;
    mem_req_t sel_req;
    logic     sel_ok;
    logic     sel_read;

    mem_rsp_t if_rsp_q, if_rsp_d;
    mem_rsp_t d_rsp_q,  d_rsp_d;

    rr_pick2 u_pick (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_if_i (bus.if_req_i),
        .req_d_i  (bus.d_req_i),
        .gnt_if_o (gnt_if),
        .gnt_d_o  (gnt_d),
        .last_o   (last)
    );

    assign gnt_any = gnt_if | gnt_d;

    // Both requests are normalised to the same record; the memory write data
    // always comes from the data port, even for a fetch grant.
    always_comb begin
        if_req       = '0;
        if_req.wen   = 1'b0;
        if_req.addr  = ADDR_MAX_W'(bus.if_addr_i);
        if_req.wdata = bus.d_wdata_i;

        d_req        = '0;
        d_req.wen    = bus.d_wen_i;
        d_req.addr   = ADDR_MAX_W'(bus.d_addr_i);
        d_req.wdata  = bus.d_wdata_i;
    end

    // Legality is only evaluated for the granted request.
    assign sel_req  = gnt_d ? d_req : if_req;
    assign sel_ok   = addr_ok(sel_req.addr, DEPTH);
    assign sel_read = sel_ok & ~sel_req.wen;

    always_comb begin
        bus.mem_wen_o   = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (gnt_any) begin
            bus.mem_wen_o   = gnt_d & sel_req.wen & sel_ok;
            bus.mem_addr_o  = sel_req.addr[ADDR_W-1:0];
            bus.mem_wdata_o = sel_req.wdata;
        end
    end

    // Response capture: the granted port loads a fresh response, the other
    // port's rvalid drops at the same edge.
    always_comb begin
        if_rsp_d = '0;
        d_rsp_d  = '0;
        if (gnt_if) begin
            if_rsp_d.rvalid = 1'b1;
            if_rsp_d.rdata  = sel_read ? bus.mem_rdata_i : 32'h0;
            if_rsp_d.err    = ~sel_ok;
        end
        if (gnt_d) begin
            d_rsp_d.rvalid = 1'b1;
            d_rsp_d.rdata  = sel_read ? bus.mem_rdata_i : 32'h0;
            d_rsp_d.err    = ~sel_ok;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if_rsp_q <= '0;
            d_rsp_q  <= '0;
        end else begin
            if_rsp_q <= if_rsp_d;
            d_rsp_q  <= d_rsp_d;
        end
    end

    assign bus.if_gnt_o    = gnt_if;
    assign bus.d_gnt_o     = gnt_d;
    assign bus.if_rvalid_o = if_rsp_q.rvalid;
    assign bus.if_rdata_o  = if_rsp_q.rdata;
    assign bus.if_err_o    = if_rsp_q.err;
    assign bus.d_rvalid_o  = d_rsp_q.rvalid;
    assign bus.d_rdata_o   = d_rsp_q.rdata;
    assign bus.d_err_o     = d_rsp_q.err;
    assign bus.dbg_last_o  = last;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing the single-ported, word-addressed 32-bit `memory` between the instruction-fetch port (read-only) and the load/store data port. Grants at most one access per cycle, drives the memory's write-enable/address/write-data, registers the memory's combinational read data, and returns it with a one-cycle-late valid. Rejects misaligned or out-of-range accesses with an error response instead of touching memory.

## Interface
- `DEPTH`, default 512: memory size in 32-bit words; legal word index is 0..DEPTH-1.
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `if_req_i` in 1: fetch request; held with `if_addr_i` stable until `if_gnt_o`.
- `if_addr_i` in ADDR_W: fetch byte address.
- `if_gnt_o` out 1: fetch granted this cycle (combinational).
- `if_rvalid_o` out 1: fetch response valid.
- `if_rdata_o` out 32: fetch read data.
- `if_err_o` out 1: fetch error (with rvalid).
- `d_req_i` in 1: data request; held with addr/wen/wdata stable until `d_gnt_o`.
- `d_wen_i` in 1: 1 = write, 0 = read.
- `d_addr_i` in ADDR_W: data byte address.
- `d_wdata_i` in 32: write data.
- `d_gnt_o` out 1: data granted this cycle (combinational).
- `d_rvalid_o` out 1: data response valid (reads and writes).
- `d_rdata_o` out 32: read data; 0 for writes.
- `d_err_o` out 1: data error (with rvalid).
- `mem_wen_o` out 1: memory write enable.
- `mem_addr_o` out ADDR_W: memory byte address.
- `mem_wdata_o` out 32: memory write data.
- `mem_rdata_i` in 32: memory combinational read data.

## Operation
- Arbitration each cycle: one requester -> it wins; both -> winner is port not granted most recently (`last_q`). `last_q` updates only on a grant.
- Reset: `last_q` = DATA, so IF wins first contention.
- Granted access: `mem_addr_o` = requester address; `mem_wdata_o` = `d_wdata_i`; `mem_wen_o` = 1 only for valid data write. Write commits at the same edge.
- No grant: `mem_wen_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
- Error check: `addr[1:0] != 0` or `addr[ADDR_W-1:2] >= DEPTH` -> still granted, `mem_wen_o` held 0, response has err=1, rdata=0.
- Response register per port: on grant edge capture `rvalid`=1, `rdata` = `mem_rdata_i` (valid read) else 0, `err`. Non-granted port's rvalid clears that edge.
- Requests are not queued; a losing port re-presents next cycle.

## Timing
- Grant: same cycle as request (combinational from req and `last_q`).
- Response latency: exactly 1 cycle after grant; rvalid is a 1-cycle pulse per grant; back-to-back grants give back-to-back rvalids.
- Both ports continuously requesting: strict alternation, each port 50% bandwidth, max wait 1 cycle.
- Write then read of same address by other port: read, one cycle later, returns new data.
- Reset values: all `*_rvalid_o`, `*_rdata_o`, `*_err_o` = 0; `last_q` = DATA; grants and memory outputs follow combinationally (0 with no requests).
- Reset asserted mid-response: rvalid/rdata/err cleared immediately (async); in-flight response lost; a write already committed at a prior edge stays.

## Structure
- Package `mem_arb_pkg`: `port_e` enum {PORT_IF, PORT_DATA}; `mem_req_t` struct {wen, addr, wdata}; `mem_rsp_t` struct {rvalid, rdata, err}; function `addr_ok(addr, depth)`.
- Sub-module `rr_pick2`: two-request round-robin pick with `last_q` state; arbiter instantiates it and one response register per port.

## Test plan
- Reset with requests low -> all rvalid/err/rdata 0, both gnt 0, `mem_wen_o`=0.
- IF-only read 0x10, mem word 4 = 0xDEADBEEF -> `if_gnt_o`=1 same cycle, next cycle `if_rvalid_o`=1, `if_rdata_o`=0xDEADBEEF, `if_err_o`=0.
- Both ports request continuously for 6 cycles after reset -> grants IF, D, IF, D, IF, D; rvalids alternate one cycle later.
- Data write 0x20 = 0x12345678, then IF read 0x20 -> `d_rvalid_o` with rdata 0; IF returns 0x12345678.
- Data write to 0x22 (misaligned) and to 0x800 (DEPTH=512) -> granted, `mem_wen_o`=0, `d_err_o`=1; words 8 and 511 unchanged.
- `rst_ni` low in cycle after a grant -> rvalid never seen high; after release, contention grants IF first.
